// File: rtl/pdu_dma_fetch.sv
// DMA fetch stage behind the PDU ring buffer: issues credit-limited reads with wrap at MAX_SLOT,
// buffers the 2-cycle-latency read data in a small skid FIFO and streams it out with sop/eop framing.
module pdu_dma_fetch #(
    parameter int PDU_DEPTH     = 512,
    parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
    parameter int MAX_SLOT      = PDU_DEPTH - 64,
    parameter int APP_IDX_WIDTH = 9,
    parameter int SKID_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dma_start,
    input  logic [PDU_AWIDTH-1:0]    dma_size,
    input  logic [PDU_AWIDTH-1:0]    dma_base_addr,
    input  logic [APP_IDX_WIDTH-1:0] dma_queue,
    output logic                     dma_done,
    output logic [PDU_AWIDTH-1:0]    rd_addr,
    output logic                     rd_en,
    input  logic                     rd_valid,
    input  logic [511:0]             rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [511:0]             out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [APP_IDX_WIDTH-1:0] out_queue,
    output logic                     busy,
    output logic                     err_start_busy
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]           SKID_LIM = (CW+1)'(SKID_DEPTH);
    localparam logic [PDU_AWIDTH:0]   SLOT_LIM = (PDU_AWIDTH+1)'(MAX_SLOT);
    localparam logic [PDU_AWIDTH-1:0] ONE_A    = {{(PDU_AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]         ONE_P    = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic [PDU_AWIDTH-1:0]    size_r, issue_cnt_r, send_cnt_r, rd_ptr_r, rd_addr_r;
    logic [PDU_AWIDTH-1:0]    ptr_src_s, ptr_next_s;
    logic [PDU_AWIDTH:0]      ptr_inc_s;
    logic [APP_IDX_WIDTH-1:0] queue_r;
    logic [CW-1:0]            inflight_r, fifo_cnt_r;
    logic [CW:0]              occ_s;
    logic [PW-1:0]            wr_idx_r, rd_idx_r;
    logic [511:0]             mem_r [SKID_DEPTH];
    logic [1:0]               age_r, age_s;
    logic                     rd_en_r, dma_done_r, err_r;
    logic                     issue_s, push_s, xfer_s, done_s, fifo_ne_s;

    assign rd_en          = rd_en_r;
    assign rd_addr        = rd_addr_r;
    assign dma_done       = dma_done_r;
    assign err_start_busy = err_r;
    assign busy           = (state_r != ST_IDLE);
    assign out_valid      = fifo_ne_s;
    assign out_data       = fifo_ne_s ? mem_r[rd_idx_r] : {512{1'b0}};
    assign out_sop        = fifo_ne_s & (send_cnt_r == size_r);
    assign out_eop        = fifo_ne_s & (send_cnt_r == ONE_A);
    assign out_queue      = queue_r;

    // Handshakes, credit occupancy (a pop this cycle frees a slot) and wrapped next read pointer
    always_comb begin
        fifo_ne_s  = (fifo_cnt_r != {CW{1'b0}});
        xfer_s     = fifo_ne_s & out_ready;
        push_s     = rd_valid & (inflight_r != {CW{1'b0}});
        occ_s      = {1'b0, inflight_r} + {1'b0, fifo_cnt_r} - {{CW{1'b0}}, xfer_s};
        ptr_src_s  = (state_r == ST_IDLE) ? dma_base_addr : rd_ptr_r;
        ptr_inc_s  = {1'b0, ptr_src_s} + {{PDU_AWIDTH{1'b0}}, 1'b1};
        ptr_next_s = (ptr_inc_s >= SLOT_LIM) ? {PDU_AWIDTH{1'b0}} : ptr_inc_s[PDU_AWIDTH-1:0];
    end

    // Next-state, read issue and done-pulse decision
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dma_start) begin
                    if (dma_size == {PDU_AWIDTH{1'b0}}) begin
                        state_s = ST_DONE_WAIT;
                    end else begin
                        state_s = ST_FETCH;
                        issue_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                issue_s = (issue_cnt_r != {PDU_AWIDTH{1'b0}}) && (occ_s < SKID_LIM);
                if (xfer_s && (send_cnt_r == ONE_A)) begin
                    state_s = ST_DONE_WAIT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DONE_WAIT: begin
                if (dma_done_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // age saturates at 3 so dma_done never fires before the third cycle after start
        if (state_r == ST_IDLE) begin
            age_s = dma_start ? 2'd1 : 2'd0;
        end else if (age_r != 2'd3) begin
            age_s = age_r + 2'd1;
        end else begin
            age_s = age_r;
        end
        done_s = (state_s == ST_DONE_WAIT) && (age_s == 2'd3);
    end

    // Request control registers, read port outputs and in-flight read accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            age_r       <= 2'd0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= {PDU_AWIDTH{1'b0}};
            rd_ptr_r    <= {PDU_AWIDTH{1'b0}};
            dma_done_r  <= 1'b0;
            err_r       <= 1'b0;
            size_r      <= {PDU_AWIDTH{1'b0}};
            issue_cnt_r <= {PDU_AWIDTH{1'b0}};
            send_cnt_r  <= {PDU_AWIDTH{1'b0}};
            queue_r     <= {APP_IDX_WIDTH{1'b0}};
            inflight_r  <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            age_r      <= age_s;
            rd_en_r    <= issue_s;
            dma_done_r <= done_s;
            if (issue_s) begin
                rd_addr_r <= ptr_src_s;
                rd_ptr_r  <= ptr_next_s;
            end
            if ((state_r == ST_IDLE) && dma_start) begin
                size_r      <= dma_size;
                queue_r     <= dma_queue;
                send_cnt_r  <= dma_size;
                issue_cnt_r <= dma_size - {{(PDU_AWIDTH-1){1'b0}}, issue_s};
            end else begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r - ONE_A;
                end
                if (xfer_s) begin
                    send_cnt_r <= send_cnt_r - ONE_A;
                end
            end
            case ({issue_s, push_s})
                2'b10:   inflight_r <= inflight_r + ONE_C;
                2'b01:   inflight_r <= inflight_r - ONE_C;
                default: inflight_r <= inflight_r;
            endcase
            if (dma_start && (state_r != ST_IDLE)) begin
                err_r <= 1'b1;
            end
        end
    end

    // Skid FIFO storage and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= {512{1'b0}};
            end
            wr_idx_r   <= {PW{1'b0}};
            rd_idx_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_idx_r] <= rd_data;
                wr_idx_r        <= wr_idx_r + ONE_P;
            end
            if (xfer_s) begin
                rd_idx_r <= rd_idx_r + ONE_P;
            end
            case ({push_s, xfer_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + ONE_C;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - ONE_C;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pdu_dma_fetch.sv
// Directed bench for pdu_dma_fetch with a 2-cycle-latency ring buffer model.
module tb_pdu_dma_fetch;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dma_start = 1'b0;
    logic [8:0]   dma_size = 9'd0;
    logic [8:0]   dma_base_addr = 9'd0;
    logic [8:0]   dma_queue = 9'd0;
    logic         dma_done;
    logic [8:0]   rd_addr;
    logic         rd_en;
    logic         rd_valid;
    logic [511:0] rd_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] out_data;
    logic         out_sop;
    logic         out_eop;
    logic [8:0]   out_queue;
    logic         busy;
    logic         err_start_busy;

    int checks = 0;
    int errors = 0;

    pdu_dma_fetch dut (
        .clk(clk), .rst_n(rst_n), .dma_start(dma_start), .dma_size(dma_size),
        .dma_base_addr(dma_base_addr), .dma_queue(dma_queue), .dma_done(dma_done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_queue(out_queue),
        .busy(busy), .err_start_busy(err_start_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] flit(input int a);
        logic [31:0] w;
        w = 32'hC0DE0000 | 32'(a);
        flit = {16{w}};
    endfunction

    // Ring buffer model: data appears two cycles after the read is sampled
    logic       p1_v = 1'b0, p2_v = 1'b0;
    logic [8:0] p1_a = 9'd0, p2_a = 9'd0;
    always @(posedge clk) begin
        p1_v <= rd_en;
        p1_a <= rd_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign rd_valid = p2_v;
    assign rd_data  = p2_v ? flit(int'(p2_a)) : {512{1'b0}};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with out_ready held high; optionally a second start while busy
    task automatic run_stream(input int base, input int size, input int q, input bit inject);
        int ndone;
        ndone = 0;
        dma_base_addr = 9'(base);
        dma_size      = 9'(size);
        dma_queue     = 9'(q);
        out_ready     = 1'b1;
        dma_start     = 1'b1;
        for (int c = 1; c <= size + 6; c++) begin
            tick();
            dma_start = inject && (c == 2);
            if (inject && (c == 2)) begin
                dma_base_addr = 9'd0;
                dma_size      = 9'd3;
                dma_queue     = 9'd1;
            end
            chk("rd_en", rd_en, c <= size);
            if (c <= size) chk("rd_addr", rd_addr, (base + c - 1) % 448);
            chk("out_valid", out_valid, (c >= 4) && (c <= size + 3));
            if ((c >= 4) && (c <= size + 3)) begin
                chk("out_data", out_data, flit((base + c - 4) % 448));
                chk("out_sop", out_sop, c == 4);
                chk("out_eop", out_eop, c == size + 3);
                chk("out_queue", out_queue, q);
            end
            chk("dma_done", dma_done, c == size + 4);
            if (dma_done) ndone++;
        end
        chk("done_count", ndone, 1);
        chk("idle_after", busy, 1'b0);
        dma_start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int nissued, nrecv, ndone;
        #12;
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", dma_done, 1'b0);
        chk("rst_err", err_start_busy, 1'b0);
        chk("rst_out_data", out_data, 512'd0);
        rst_n = 1'b1;
        tick();
        tick();

        run_stream(10, 1, 5, 1'b0);
        run_stream(100, 8, 9, 1'b0);
        run_stream(446, 4, 4, 1'b0);
        chk("no_err_yet", err_start_busy, 1'b0);

        // Backpressure: only four credits may be issued while out_ready is low
        dma_base_addr = 9'd200; dma_size = 9'd10; dma_queue = 9'd3;
        out_ready = 1'b0; dma_start = 1'b1; nissued = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            dma_start = 1'b0;
            if (rd_en) nissued++;
            chk("bp_rd_en", rd_en, c <= 4);
            chk("bp_valid", out_valid, c >= 4);
            if (c >= 4) chk("bp_head", out_data, flit(200));
        end
        chk("bp_issued4", nissued, 4);
        nrecv = 0; ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            out_ready = (i % 3) != 1;
            if (rd_en) nissued++;
            if (dma_done) ndone++;
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, flit(200 + nrecv));
                chk("bp_sop", out_sop, nrecv == 0);
                chk("bp_eop", out_eop, nrecv == 9);
                chk("bp_queue", out_queue, 9'd3);
                nrecv++;
            end
        end
        chk("bp_recv", nrecv, 10);
        chk("bp_issued", nissued, 10);
        chk("bp_done", ndone, 1);
        chk("bp_idle", busy, 1'b0);
        out_ready = 1'b1;

        // Zero-size request: done exactly three cycles after start
        dma_base_addr = 9'd7; dma_size = 9'd0; dma_queue = 9'd2; dma_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            dma_start = 1'b0;
            chk("z_rd_en", rd_en, 1'b0);
            chk("z_valid", out_valid, 1'b0);
            chk("z_done", dma_done, c == 3);
            chk("z_busy", busy, c <= 3);
        end

        run_stream(300, 16, 7, 1'b1);
        chk("err_sticky", err_start_busy, 1'b1);

        // Reset after three issued reads
        dma_base_addr = 9'd50; dma_size = 9'd10; dma_queue = 9'd6; dma_start = 1'b1;
        nissued = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            dma_start = 1'b0;
            if (rd_en) nissued++;
        end
        chk("rr_issued3", nissued, 3);
        rst_n = 1'b0;
        #1;
        chk("rr_rd_en", rd_en, 1'b0);
        chk("rr_rd_addr", rd_addr, 9'd0);
        chk("rr_busy", busy, 1'b0);
        chk("rr_err", err_start_busy, 1'b0);
        chk("rr_queue", out_queue, 9'd0);
        chk("rr_valid", out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rr_late_valid", out_valid, 1'b0);
            chk("rr_late_busy", busy, 1'b0);
        end
        run_stream(20, 3, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
